// File: rtl/uart_frame_rx.sv
// UART receiver with a 4-byte frame assembler (A5 sync, E-pass/speed payload, XOR checksum).
// Reports good frames on frame_valid and framing/checksum/timeout errors on frame_err.
module uart_frame_rx #(
    parameter int unsigned SYS_FREQ     = 50000000,
    parameter int unsigned BAUD         = 9600,
    parameter int unsigned WIDTH_SPEED  = 14,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   serial_data_in,
    output logic [WIDTH_SPEED-1:0] speed,
    output logic [1:0]             valid_Epass,
    output logic                   frame_valid,
    output logic                   frame_err
);

    localparam int unsigned BIT_CLKS     = SYS_FREQ / BAUD;
    localparam int unsigned HALF_CLKS    = BIT_CLKS / 2;
    localparam int unsigned CNT_W        = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam int unsigned TIMEOUT_CLKS = TIMEOUT_BITS * BIT_CLKS;
    localparam int unsigned TO_W         = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [7:0]  SYNC_BYTE    = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {FR_SYNC, FR_B1, FR_B2, FR_CHK} fr_state_t;

    rx_state_t        rx_state;
    fr_state_t        fr_state;
    logic             sync_q1;
    logic             sync_q2;
    logic             line_prev;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_q;
    logic             stop_wait;
    logic [7:0]       byte1_q;
    logic [7:0]       byte2_q;
    logic [TO_W-1:0]  to_cnt;

    logic             fall_c;
    logic             stop_hit_c;
    logic             byte_ok_c;
    logic             frame_bad_c;
    logic [13:0]      speed_field_c;

    assign fall_c        = line_prev & ~sync_q2;
    assign stop_hit_c    = (rx_state == RX_STOP) && !stop_wait && (bit_cnt == CNT_W'(BIT_CLKS - 1));
    assign byte_ok_c     = stop_hit_c & sync_q2;
    assign frame_bad_c   = stop_hit_c & ~sync_q2;
    assign speed_field_c = {byte1_q[5:0], byte2_q};

    // Two-flop synchronizer plus one delayed copy for edge detection; idles high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1   <= 1'b1;
            sync_q2   <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            sync_q1   <= serial_data_in;
            sync_q2   <= sync_q1;
            line_prev <= sync_q2;
        end
    end

    // Byte receiver: mid-bit sampling, LSB first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state  <= RX_IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift_q   <= '0;
            stop_wait <= 1'b0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    bit_cnt   <= '0;
                    stop_wait <= 1'b0;
                    if (fall_c) rx_state <= RX_START;
                end
                RX_START: begin
                    if (bit_cnt == CNT_W'(HALF_CLKS - 1)) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        rx_state <= sync_q2 ? RX_IDLE : RX_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (bit_cnt == CNT_W'(BIT_CLKS - 1)) begin
                        bit_cnt <= '0;
                        shift_q <= {sync_q2, shift_q[7:1]};
                        if (bit_idx == 3'd7) rx_state <= RX_STOP;
                        else                 bit_idx  <= bit_idx + 3'd1;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    // A low stop bit holds here until the line recovers.
                    if (stop_wait) begin
                        if (sync_q2) begin
                            stop_wait <= 1'b0;
                            rx_state  <= RX_IDLE;
                        end
                    end else if (bit_cnt == CNT_W'(BIT_CLKS - 1)) begin
                        bit_cnt <= '0;
                        if (sync_q2) rx_state  <= RX_IDLE;
                        else         stop_wait <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Frame assembler, evaluated at the stop-bit sample so results land one clock later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fr_state    <= FR_SYNC;
            byte1_q     <= '0;
            byte2_q     <= '0;
            to_cnt      <= '0;
            speed       <= '0;
            valid_Epass <= 2'b00;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (frame_bad_c) begin
                frame_err <= 1'b1;
                fr_state  <= FR_SYNC;
                to_cnt    <= '0;
            end else if (byte_ok_c) begin
                to_cnt <= '0;
                case (fr_state)
                    FR_SYNC: if (shift_q == SYNC_BYTE) fr_state <= FR_B1;
                    FR_B1: begin
                        byte1_q  <= shift_q;
                        fr_state <= FR_B2;
                    end
                    FR_B2: begin
                        byte2_q  <= shift_q;
                        fr_state <= FR_CHK;
                    end
                    FR_CHK: begin
                        if (shift_q == (SYNC_BYTE ^ byte1_q ^ byte2_q)) begin
                            speed       <= WIDTH_SPEED'(speed_field_c);
                            valid_Epass <= byte1_q[7:6];
                            frame_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        fr_state <= FR_SYNC;
                    end
                    default: fr_state <= FR_SYNC;
                endcase
            end else if (fr_state != FR_SYNC && rx_state == RX_IDLE) begin
                // Inter-byte gap timer; paused while a byte is being received.
                if (to_cnt == TO_W'(TIMEOUT_CLKS - 1)) begin
                    frame_err <= 1'b1;
                    fr_state  <= FR_SYNC;
                    to_cnt    <= '0;
                end else begin
                    to_cnt <= to_cnt + TO_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed and randomized frame stimulus for uart_frame_rx, checked against a
// byte-queue model of the frame protocol.
module tb_uart_frame_rx;

    localparam int unsigned BAUD     = 9600;
    localparam int unsigned BIT_CLKS = 128;
    localparam int unsigned SYS_FREQ = BAUD * BIT_CLKS;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        serial_data_in = 1'b1;
    logic [13:0] speed;
    logic [1:0]  valid_Epass;
    logic        frame_valid;
    logic        frame_err;

    uart_frame_rx #(
        .SYS_FREQ    (SYS_FREQ),
        .BAUD        (BAUD),
        .WIDTH_SPEED (14),
        .TIMEOUT_BITS(20)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .serial_data_in(serial_data_in),
        .speed         (speed),
        .valid_Epass   (valid_Epass),
        .frame_valid   (frame_valid),
        .frame_err     (frame_err)
    );

    always #10 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge.
    int   n_valid = 0;
    int   n_err = 0;
    int   n_overlap = 0;
    int   n_wide = 0;
    int   err_cyc = 0;
    logic pv = 1'b0;
    logic pe = 1'b0;
    always @(negedge clk) begin
        if (frame_valid) n_valid++;
        if (frame_err) begin
            n_err++;
            if (!pe) err_cyc = cyc;
        end
        if (frame_valid && frame_err) n_overlap++;
        if ((frame_valid && pv) || (frame_err && pe)) n_wide++;
        pv = frame_valid;
        pe = frame_err;
    end

    // Reference model: bytes collected since the last sync, resolved every 4 bytes.
    bit [7:0]  mq[$];
    bit [13:0] exp_speed = '0;
    bit [1:0]  exp_epass = '0;
    int        exp_valid = 0;
    int        exp_err   = 0;
    int        last_stop_cyc = 0;

    task automatic model_byte(input bit [7:0] b);
        if (mq.size() == 0 && b != 8'hA5) return;
        mq.push_back(b);
        if (mq.size() == 4) begin
            if ((mq[0] ^ mq[1] ^ mq[2]) == mq[3]) begin
                exp_epass = mq[1][7:6];
                exp_speed = {mq[1][5:0], mq[2]};
                exp_valid++;
            end else begin
                exp_err++;
            end
            mq.delete();
        end
    endtask

    task automatic model_error();
        mq.delete();
        exp_err++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_valid_count"}, 32'(n_valid), 32'(exp_valid));
        check({tag, "_err_count"}, 32'(n_err), 32'(exp_err));
        check({tag, "_speed"}, 32'(speed), 32'(exp_speed));
        check({tag, "_epass"}, 32'(valid_Epass), 32'(exp_epass));
    endtask

    task automatic idle_bits(input int n);
        serial_data_in = 1'b1;
        repeat (n * BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_byte(input bit [7:0] b, input bit stop_val);
        serial_data_in = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serial_data_in = b[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        last_stop_cyc  = cyc;
        serial_data_in = stop_val;
        repeat (BIT_CLKS) @(negedge clk);
        if (stop_val) model_byte(b);
        else          model_error();
    endtask

    task automatic send4(input bit [7:0] b0, input bit [7:0] b1, input bit [7:0] b2, input bit [7:0] b3);
        send_byte(b0, 1'b1);
        send_byte(b1, 1'b1);
        send_byte(b2, 1'b1);
        send_byte(b3, 1'b1);
    endtask

    task automatic send_rand_frame(input bit corrupt);
        bit [13:0] sp;
        bit [1:0]  ep;
        bit [7:0]  b1, b2, b3, flip;
        sp   = 14'($urandom_range(0, 16383));
        ep   = 2'($urandom_range(0, 3));
        b1   = {ep, sp[13:8]};
        b2   = sp[7:0];
        flip = 8'h01 << $urandom_range(0, 7);
        b3   = 8'hA5 ^ b1 ^ b2 ^ (corrupt ? flip : 8'h00);
        send4(8'hA5, b1, b2, b3);
    endtask

    initial begin
        int       d;
        bit [7:0] g;

        // Reset state
        repeat (5) @(negedge clk);
        check_state("reset");
        check("reset_frame_valid", 32'(frame_valid), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        reset_n = 1'b1;
        idle_bits(2);

        // Known good frame
        send4(8'hA5, 8'h88, 8'hCA, 8'hE7);
        check_state("good");
        check("good_speed_const", 32'(speed), 32'd2250);
        check("good_epass_const", 32'(valid_Epass), 32'd2);

        // Checksum error keeps outputs, next frame still accepted
        send4(8'hA5, 8'h88, 8'hCA, 8'hE6);
        check_state("cksum");
        check("cksum_speed_kept", 32'(speed), 32'd2250);
        send_rand_frame(1'b0);
        check_state("after_cksum");

        // Framing error on byte2 stop bit, then a fresh frame
        send_byte(8'hA5, 1'b1);
        send_byte(8'h40, 1'b1);
        send_byte(8'h10, 1'b0);
        idle_bits(2);
        check_state("framing");
        send4(8'hA5, 8'h40, 8'h10, 8'hF5);
        check_state("after_framing");
        check("after_framing_speed_const", 32'(speed), 32'h0010);
        check("after_framing_epass_const", 32'(valid_Epass), 32'd1);

        // Inter-byte timeout; the late byte is discarded in sync hunt
        send_byte(8'hA5, 1'b1);
        d = last_stop_cyc + BIT_CLKS / 2 + 20 * BIT_CLKS + 3;
        idle_bits(25);
        model_error();
        send_byte(8'h88, 1'b1);
        idle_bits(2);
        check_state("timeout");
        d = (err_cyc > d) ? err_cyc - d : d - err_cyc;
        check("timeout_timing_ok", 32'(d <= 8), 32'd1);

        // Short glitch on the idle line followed directly by a frame
        serial_data_in = 1'b0;
        #1000;
        serial_data_in = 1'b1;
        send_rand_frame(1'b0);
        check_state("glitch");

        // Reset during the data bits of byte1
        send_byte(8'hA5, 1'b1);
        serial_data_in = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            serial_data_in = 1'($urandom_range(0, 1));
            repeat (BIT_CLKS) @(negedge clk);
        end
        reset_n = 1'b0;
        #1;
        check("midreset_speed", 32'(speed), 32'd0);
        check("midreset_epass", 32'(valid_Epass), 32'd0);
        check("midreset_frame_valid", 32'(frame_valid), 32'd0);
        check("midreset_frame_err", 32'(frame_err), 32'd0);
        mq.delete();
        exp_speed = '0;
        exp_epass = '0;
        idle_bits(2);
        reset_n = 1'b1;
        idle_bits(1);
        send_rand_frame(1'b0);
        check_state("after_reset");

        // Random back-to-back frames preceded by a non-sync byte
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h5A;
        send_byte(g, 1'b1);
        for (int k = 0; k < 3; k++) begin
            send_rand_frame($urandom_range(0, 2) == 0);
        end
        idle_bits(1);
        check_state("random");

        check("pulse_overlap", 32'(n_overlap), 32'd0);
        check("pulse_width", 32'(n_wide), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
